// File: rtl/slice_compare_sequencer_if.sv
// Bundle of signals between the slice compare sequencer, its operand producer,
// its result consumer and the shared 2-bit comparator slice.
interface slice_compare_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH / 2) + 1
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic             slice_a_gt;
    logic             slice_eq;
    logic             slice_b_gt;
    logic             result_valid;
    logic             result_ready;
    logic             a_greater;
    logic             equal;
    logic             b_greater;
    logic             error;
    logic [CW-1:0]    slice_count;
    logic             busy;

    // Environment side: operand producer, comparator slice and result consumer.
    modport master (
        output start_valid, a, b, slice_a_gt, slice_eq, slice_b_gt, result_ready,
        input  start_ready, slice_a, slice_b, result_valid, a_greater, equal,
               b_greater, error, slice_count, busy
    );

    modport slave (
        input  start_valid, a, b, slice_a_gt, slice_eq, slice_b_gt, result_ready,
        output start_ready, slice_a, slice_b, result_valid, a_greater, equal,
               b_greater, error, slice_count, busy
    );
endinterface

// File: rtl/slice_compare_sequencer.sv
// Compares two WIDTH-bit operands MSB-first through one shared 2-bit comparator
// slice, stopping at the first unequal slice, and returns a one-hot result.
module slice_compare_sequencer #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH / 2) + 1
) (
    input logic                   clk,
    input logic                   rst_n,
    slice_compare_sequencer_if.slave bus
);
    localparam int NS = WIDTH / 2;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NS - 1);

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("slice_compare_sequencer: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IW-1:0]    idx;
    logic             a_greater_r;
    logic             equal_r;
    logic             b_greater_r;
    logic             error_r;
    logic [CW-1:0]    slice_count_r;
    logic [1:0]       slice_a_c;
    logic [1:0]       slice_b_c;
    logic             flags_onehot;

    // The comparator answers combinationally, so the slice must follow idx directly.
    always_comb begin
        slice_a_c = 2'b00;
        slice_b_c = 2'b00;
        if (state == COMPARE) begin
            slice_a_c = a_reg[int'(idx) * 2 +: 2];
            slice_b_c = b_reg[int'(idx) * 2 +: 2];
        end
    end

    assign flags_onehot = ( bus.slice_a_gt & ~bus.slice_eq & ~bus.slice_b_gt) |
                          (~bus.slice_a_gt &  bus.slice_eq & ~bus.slice_b_gt) |
                          (~bus.slice_a_gt & ~bus.slice_eq &  bus.slice_b_gt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            idx           <= IDX_TOP;
            a_greater_r   <= 1'b0;
            equal_r       <= 1'b0;
            b_greater_r   <= 1'b0;
            error_r       <= 1'b0;
            slice_count_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_reg         <= bus.a;
                        b_reg         <= bus.b;
                        idx           <= IDX_TOP;
                        slice_count_r <= '0;
                        a_greater_r   <= 1'b0;
                        equal_r       <= 1'b0;
                        b_greater_r   <= 1'b0;
                        error_r       <= 1'b0;
                        state         <= COMPARE;
                    end
                end
                COMPARE: begin
                    slice_count_r <= slice_count_r + CW'(1);
                    // A broken comparator must never be reported as a valid ordering.
                    if (!flags_onehot) begin
                        error_r <= 1'b1;
                        state   <= DONE;
                    end else if (bus.slice_a_gt) begin
                        a_greater_r <= 1'b1;
                        state       <= DONE;
                    end else if (bus.slice_b_gt) begin
                        b_greater_r <= 1'b1;
                        state       <= DONE;
                    end else if (idx == '0) begin
                        equal_r <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_ready  = (state == IDLE);
    assign bus.result_valid = (state == DONE);
    assign bus.busy         = (state != IDLE);
    assign bus.slice_a      = slice_a_c;
    assign bus.slice_b      = slice_b_c;
    assign bus.a_greater    = a_greater_r;
    assign bus.equal        = equal_r;
    assign bus.b_greater    = b_greater_r;
    assign bus.error        = error_r;
    assign bus.slice_count  = slice_count_r;
endmodule

// File: tb/tb_slice_compare_sequencer.sv
// Scoreboard bench for slice_compare_sequencer: an ideal (or faulty) comparator
// slice model answers the DUT, and expected results are queued at each accept.
module tb_slice_compare_sequencer;
    localparam int WIDTH = 8;
    localparam int NS    = WIDTH / 2;
    localparam int CW    = $clog2(NS) + 1;

    typedef struct {
        logic [3:0] flags;   // {a_greater, equal, b_greater, error}
        int         count;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic fault_mode = 1'b0;

    exp_t       sb[$];
    logic [3:0] seen_slices[$];
    int         vectors     = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    slice_compare_sequencer_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    slice_compare_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Comparator slice model; fault_mode forces a non-one-hot answer.
    always_comb begin
        if (fault_mode) begin
            bus.slice_a_gt = 1'b1;
            bus.slice_eq   = 1'b1;
            bus.slice_b_gt = 1'b0;
        end else begin
            bus.slice_a_gt = (bus.slice_a >  bus.slice_b);
            bus.slice_eq   = (bus.slice_a == bus.slice_b);
            bus.slice_b_gt = (bus.slice_a <  bus.slice_b);
        end
    end

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic fault);
        exp_t       e;
        logic [1:0] sa;
        logic [1:0] sbv;
        e.flags = 4'b0000;
        e.count = 0;
        for (int s = NS - 1; s >= 0; s--) begin
            sa  = a[2 * s +: 2];
            sbv = b[2 * s +: 2];
            e.count++;
            if (fault) begin
                e.flags = 4'b0001;
                return e;
            end
            if (sa > sbv) begin
                e.flags = 4'b1000;
                return e;
            end
            if (sa < sbv) begin
                e.flags = 4'b0010;
                return e;
            end
        end
        e.flags = 4'b0100;
        return e;
    endfunction

    // Called at a negedge while idle; returns at the negedge after the accept edge.
    task automatic send_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.a           = a;
        bus.b           = b;
        bus.start_valid = 1'b1;
        sb.push_back(model(a, b, fault_mode));
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.a           = WIDTH'($urandom);
        bus.b           = WIDTH'($urandom);
    endtask

    // Waits for result_valid, logging presented slices; counts cycles waited.
    task automatic wait_result(input int limit, output int cycles, output bit ok);
        cycles = 0;
        seen_slices.delete();
        while (!bus.result_valid && cycles < limit) begin
            if (bus.busy) seen_slices.push_back({bus.slice_a, bus.slice_b});
            @(negedge clk);
            cycles++;
        end
        ok = bus.result_valid;
    endtask

    task automatic test_reset();
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b1;
        bus.a            = '0;
        bus.b            = '0;
        rst_n            = 1'b0;
        repeat (2) @(negedge clk);
        if (bus.start_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_start_ready: got %b expected 1", bus.start_ready);
        end
        vectors++;
        if ({bus.result_valid, bus.busy} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_valid_busy: got %b expected 00", {bus.result_valid, bus.busy});
        end
        vectors++;
        if ({bus.a_greater, bus.equal, bus.b_greater, bus.error, bus.slice_count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags_count: got flags %b count %0d expected 0",
                     {bus.a_greater, bus.equal, bus.b_greater, bus.error}, bus.slice_count);
        end
        vectors++;
        if ({bus.slice_a, bus.slice_b} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_slices: got %b expected 0000", {bus.slice_a, bus.slice_b});
        end
        vectors++;
        rst_n = 1'b1;
        @(negedge clk);
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got ready %b busy %b expected 1 0",
                     bus.start_ready, bus.busy);
        end
        vectors++;
    endtask

    task automatic test_a_greater();
        exp_t e;
        int   cyc;
        bit   ok;
        bus.result_ready = 1'b1;
        send_op(8'hB4, 8'h74);
        wait_result(NS + 2, cyc, ok);
        e = sb.pop_front();
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL a_greater_timeout: result_valid never rose in %0d cycles", cyc);
        end
        vectors++;
        if ({bus.a_greater, bus.equal, bus.b_greater, bus.error} !== 4'b1000 ||
            {bus.a_greater, bus.equal, bus.b_greater, bus.error} !== e.flags) begin
            miscompares++;
            $display("[TB] FAIL a_greater_flags: got %b expected %b",
                     {bus.a_greater, bus.equal, bus.b_greater, bus.error}, e.flags);
        end
        vectors++;
        if (int'(bus.slice_count) !== e.count || cyc !== e.count) begin
            miscompares++;
            $display("[TB] FAIL a_greater_count: got count %0d latency %0d expected %0d",
                     bus.slice_count, cyc, e.count);
        end
        vectors++;
        @(negedge clk);
        if (bus.result_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL a_greater_pulse: got valid %b ready %b expected 0 1",
                     bus.result_valid, bus.start_ready);
        end
        vectors++;
    endtask

    task automatic test_slice_order();
        exp_t       e;
        int         cyc;
        bit         ok;
        logic [3:0] want[NS] = '{4'b0101, 4'b0101, 4'b1010, 4'b1011};
        bus.result_ready = 1'b1;
        send_op(8'h5A, 8'h5B);
        wait_result(NS + 2, cyc, ok);
        e = sb.pop_front();
        if (!ok || {bus.a_greater, bus.equal, bus.b_greater, bus.error} !== e.flags) begin
            miscompares++;
            $display("[TB] FAIL order_flags: got valid %b flags %b expected 1 %b", ok,
                     {bus.a_greater, bus.equal, bus.b_greater, bus.error}, e.flags);
        end
        vectors++;
        if (int'(bus.slice_count) !== 4 || cyc !== e.count) begin
            miscompares++;
            $display("[TB] FAIL order_count: got count %0d latency %0d expected 4",
                     bus.slice_count, cyc);
        end
        vectors++;
        if (seen_slices.size() !== NS) begin
            miscompares++;
            $display("[TB] FAIL order_len: got %0d slices expected %0d", seen_slices.size(), NS);
        end
        vectors++;
        for (int i = 0; i < NS && i < seen_slices.size(); i++) begin
            if (seen_slices[i] !== want[i]) begin
                miscompares++;
                $display("[TB] FAIL order_slice%0d: got a/b %b expected %b", i, seen_slices[i], want[i]);
            end
            vectors++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        bit   ok;
        bus.result_ready = 1'b1;
        send_op(8'hC3, 8'hC3);
        wait_result(NS + 2, cyc, ok);
        e = sb.pop_front();
        if (!ok || {bus.a_greater, bus.equal, bus.b_greater, bus.error} !== 4'b0100 ||
            int'(bus.slice_count) !== e.count) begin
            miscompares++;
            $display("[TB] FAIL b2b_equal: got valid %b flags %b count %0d expected 1 0100 %0d",
                     ok, {bus.a_greater, bus.equal, bus.b_greater, bus.error}, bus.slice_count, e.count);
        end
        vectors++;
        @(negedge clk);
        if (bus.start_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_ready: got %b expected 1", bus.start_ready);
        end
        vectors++;
        send_op(8'h00, 8'h40);
        wait_result(NS + 2, cyc, ok);
        e = sb.pop_front();
        if (!ok || {bus.a_greater, bus.equal, bus.b_greater, bus.error} !== 4'b0010 ||
            int'(bus.slice_count) !== 1 || cyc !== e.count) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: got valid %b flags %b count %0d latency %0d expected 1 0010 1 1",
                     ok, {bus.a_greater, bus.equal, bus.b_greater, bus.error}, bus.slice_count, cyc);
        end
        vectors++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        bit   ok;
        bus.result_ready = 1'b0;
        send_op(8'hFF, 8'h00);
        wait_result(NS + 2, cyc, ok);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            if (bus.result_valid !== 1'b1 || bus.start_ready !== 1'b0 ||
                {bus.a_greater, bus.equal, bus.b_greater, bus.error} !== e.flags ||
                int'(bus.slice_count) !== e.count) begin
                miscompares++;
                $display("[TB] FAIL stall_hold%0d: got valid %b ready %b flags %b count %0d expected 1 0 %b %0d",
                         i, bus.result_valid, bus.start_ready,
                         {bus.a_greater, bus.equal, bus.b_greater, bus.error}, bus.slice_count,
                         e.flags, e.count);
            end
            vectors++;
            bus.a           = 8'h00;
            bus.b           = 8'hFF;
            bus.start_valid = 1'b1;
            #2;
            bus.start_valid = 1'b0;
            @(negedge clk);
        end
        bus.result_ready = 1'b1;
        @(negedge clk);
        if (bus.result_valid !== 1'b0 || bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_release: got valid %b ready %b busy %b expected 0 1 0",
                     bus.result_valid, bus.start_ready, bus.busy);
        end
        vectors++;
        if ({bus.a_greater, bus.equal, bus.b_greater, bus.error} !== 4'b1000 || sb.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL stall_held_flags: got flags %b pending %0d expected 1000 0",
                     {bus.a_greater, bus.equal, bus.b_greater, bus.error}, sb.size());
        end
        vectors++;
    endtask

    task automatic test_reset_mid_op();
        bit seen_valid;
        bus.result_ready = 1'b1;
        send_op(8'h55, 8'h55);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_state: got ready %b busy %b valid %b expected 1 0 0",
                     bus.start_ready, bus.busy, bus.result_valid);
        end
        vectors++;
        if ({bus.a_greater, bus.equal, bus.b_greater, bus.error, bus.slice_count,
             bus.slice_a, bus.slice_b} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrst_outputs: got flags %b count %0d slices %b expected all 0",
                     {bus.a_greater, bus.equal, bus.b_greater, bus.error}, bus.slice_count,
                     {bus.slice_a, bus.slice_b});
        end
        vectors++;
        void'(sb.pop_back());
        @(negedge clk);
        rst_n      = 1'b1;
        seen_valid = 1'b0;
        repeat (NS + 3) begin
            @(negedge clk);
            if (bus.result_valid || bus.busy) seen_valid = 1'b1;
        end
        if (seen_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_no_result: got activity %b expected 0", seen_valid);
        end
        vectors++;
    endtask

    task automatic test_fault();
        exp_t e;
        int   cyc;
        bit   ok;
        bus.result_ready = 1'b1;
        fault_mode       = 1'b1;
        send_op(8'h12, 8'h34);
        wait_result(NS + 2, cyc, ok);
        e = sb.pop_front();
        if (!ok || {bus.a_greater, bus.equal, bus.b_greater, bus.error} !== 4'b0001 ||
            {bus.a_greater, bus.equal, bus.b_greater, bus.error} !== e.flags) begin
            miscompares++;
            $display("[TB] FAIL fault_flags: got valid %b flags %b expected 1 0001",
                     ok, {bus.a_greater, bus.equal, bus.b_greater, bus.error});
        end
        vectors++;
        if (int'(bus.slice_count) !== 1 || cyc !== e.count) begin
            miscompares++;
            $display("[TB] FAIL fault_count: got count %0d latency %0d expected 1",
                     bus.slice_count, cyc);
        end
        vectors++;
        @(negedge clk);
        fault_mode = 1'b0;
    endtask

    task automatic test_random();
        exp_t             e;
        int               cyc;
        bit               ok;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        bus.result_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ra = WIDTH'($urandom);
            case (i % 3)
                0:       rb = ra;
                1:       rb = ra ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
                default: rb = WIDTH'($urandom);
            endcase
            send_op(ra, rb);
            wait_result(NS + 2, cyc, ok);
            e = sb.pop_front();
            if (!ok || {bus.a_greater, bus.equal, bus.b_greater, bus.error} !== e.flags ||
                int'(bus.slice_count) !== e.count || cyc !== e.count) begin
                miscompares++;
                $display("[TB] FAIL random%0d a=%h b=%h: got valid %b flags %b count %0d latency %0d expected 1 %b %0d",
                         i, ra, rb, ok, {bus.a_greater, bus.equal, bus.b_greater, bus.error},
                         bus.slice_count, cyc, e.flags, e.count);
            end
            vectors++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_a_greater();
        test_slice_order();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        test_fault();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/slice_compare_sequencer.md
Name: slice_compare_sequencer

Overview:
- Sequential controller that compares two WIDTH-bit operands using one shared external 2-bit magnitude comparator slice.
- Presents 2-bit slice pairs to the comparator MSB-first, one slice per cycle, and samples the slice's greater/equal/lesser flags.
- Stops at the first unequal slice and returns a one-hot result through a valid/ready handshake.
- Sits between operand producers and the existing 2-bit dataflow comparator, so wide compares reuse that slice instead of a wide comparator.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2. NS = WIDTH/2 slices.
- CW, $clog2(WIDTH/2)+1, width of slice_count. Holds values 0..NS.

Ports:
- clk  input  1  single clock. All state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  operand pair on a/b is valid.
- start_ready  output  1  controller can accept operands. High only in IDLE.
- a  input  WIDTH  operand A. Sampled on an accept.
- b  input  WIDTH  operand B. Sampled on an accept.
- slice_a  output  2  current slice of latched A, driven to the comparator.
- slice_b  output  2  current slice of latched B, driven to the comparator.
- slice_a_gt  input  1  comparator flag: slice_a > slice_b (combinational return).
- slice_eq  input  1  comparator flag: slice_a == slice_b.
- slice_b_gt  input  1  comparator flag: slice_b > slice_a.
- result_valid  output  1  result flags are valid.
- result_ready  input  1  consumer accepts the result.
- a_greater  output  1  result: A > B.
- equal  output  1  result: A == B.
- b_greater  output  1  result: B > A.
- error  output  1  comparator returned a non-one-hot flag set.
- slice_count  output  CW  number of slices examined for the current result.
- busy  output  1  high in COMPARE or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; operand regs=0; idx=NS-1; result flags, error, result_valid=0; slice_count=0; slice_a=slice_b=0; busy=0; start_ready=1. Applies immediately, including mid-COMPARE or mid-DONE; any in-flight compare is discarded with no result.
- FSM states: IDLE, COMPARE, DONE.
- start_ready = (state==IDLE). result_valid = (state==DONE). busy = (state!=IDLE).
- IDLE: on start_valid & start_ready at an edge:
  - latch a and b; idx<=NS-1; slice_count<=0; clear result flags and error;
  - go to COMPARE.
- COMPARE:
  - slice_a = a_reg[2*idx+1:2*idx], slice_b = b_reg[2*idx+1:2*idx] (combinational from idx). The comparator responds in the same cycle.
  - Each edge: slice_count<=slice_count+1, then evaluate the flags:
    - flags not exactly one-hot: error<=1, all result flags 0, go to DONE.
    - slice_a_gt: a_greater<=1, go to DONE.
    - slice_b_gt: b_greater<=1, go to DONE.
    - slice_eq and idx==0: equal<=1, go to DONE.
    - slice_eq and idx>0: idx<=idx-1, stay in COMPARE.
- DONE:
  - result flags, error and slice_count held stable while result_ready=0 (no limit on stall length).
  - on result_ready, go to IDLE. Flags stay held until the next accept clears them; result_valid drops.
- Slice outputs are 0 outside COMPARE.
- Latency: accept edge, then k COMPARE cycles (1<=k<=NS), then result_valid=1 in the next cycle. Best case 1 cycle, worst case NS cycles of COMPARE.
- Throughput: there is no accept in DONE. The earliest next accept is in the cycle after result handshake (one IDLE cycle).
- Flags a_greater/equal/b_greater/error: exactly one is 1 whenever result_valid=1.
- start_valid while busy: ignored, with no side effects. a/b may change freely outside the accept edge.

Test Plan:
- WIDTH=8, a=8'hB4, b=8'h74, ideal comparator model, result_ready=1 -> a_greater=1 after 1 COMPARE cycle, slice_count=1, result_valid pulses for 1 cycle.
- a=8'h5A, b=8'h5B -> slices 01/01, 01/01, 10/10, 10/11 presented in order. b_greater=1, slice_count=4, result_valid 4 cycles after accept edge+1.
- a=b=8'hC3 -> equal=1, slice_count=4. Then a=8'h00, b=8'h40 accepted 1 cycle after the handshake -> b_greater=1, slice_count=1.
- Backpressure: a=8'hFF, b=8'h00, result_ready=0 for 5 cycles -> a_greater and result_valid held 5 cycles, start_ready=0, start_valid pulses ignored. After result_ready=1, start_ready=1 the next cycle.
- Reset mid-op: a=8'h55, b=8'h55, assert rst_n=0 during the 2nd COMPARE cycle -> all outputs 0, start_ready=1 immediately (asynchronous), no result_valid after release.
- Fault: comparator model drives slice_eq=1 and slice_a_gt=1 on the first slice -> error=1, a_greater=equal=b_greater=0, slice_count=1.
